// File: rtl/phase_a_loader.sv
// phase_a_loader: collects operand and key frames from a W-bit inbound stream,
// holds them steady for the phase_a stage, fires phase_a with a one-cycle
// start pulse, and streams the returned result back out, least-significant
// word first. Assumes NW = Size/W >= 2 and radix+2 <= W.
module phase_a_loader #(
   parameter int Size  = 3072,
   parameter int radix = 54,
   parameter int W     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   // inbound word stream
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic                 in_kind,
   // operands toward phase_a
   output logic [Size-1:0]      pa_a,
   output logic [Size-1:0]      pa_m,
   output logic [Size+1:0]      pa_m_n,
   output logic [radix+1:0]     pa_m_prime,
   output logic                 pa_en,
   input  logic                 pa_done,
   input  logic [Size-1:0]      pa_new_a,
   // outbound result stream
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic                 out_last,
   // status
   output logic                 key_valid,
   output logic                 busy,
   output logic                 err
);

   localparam int NW = Size / W;
   localparam int CW = $clog2(NW + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_M  = 3'd2,
      LOAD_MN = 3'd3,
      LOAD_MP = 3'd4,
      FIRE    = 3'd5,
      WAIT    = 3'd6,
      UNLOAD  = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [Size-1:0]   pa_a_q, pa_a_d;
   logic [Size-1:0]   pa_m_q, pa_m_d;
   logic [Size+1:0]   pa_m_n_q, pa_m_n_d;
   logic [radix+1:0]  pa_m_prime_q, pa_m_prime_d;
   logic [Size-1:0]   result_q, result_d;
   logic              key_valid_q, key_valid_d;
   logic              err_q, err_d;
   logic              pa_en_q, pa_en_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [W-1:0]      out_data_q, out_data_d;

   logic              in_fire_s;
   logic              out_fire_s;
   logic              last_word_s;

   assign in_fire_s   = in_valid & in_ready_q;
   assign out_fire_s  = out_valid_q & out_ready;
   assign last_word_s = (cnt_q == CW'(NW - 1));

   // Next-state and datapath: frame loading, firing, result capture, unload counting.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pa_a_d       = pa_a_q;
      pa_m_d       = pa_m_q;
      pa_m_n_d     = pa_m_n_q;
      pa_m_prime_d = pa_m_prime_q;
      result_d     = result_q;
      key_valid_d  = key_valid_q;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_fire_s) begin
               cnt_d = CW'(1);
               if (in_kind) begin
                  // a new key invalidates the old one until it is complete
                  pa_m_d[W-1:0] = in_data;
                  key_valid_d   = 1'b0;
                  state_d       = LOAD_M;
               end else begin
                  pa_a_d[W-1:0] = in_data;
                  state_d       = LOAD_A;
               end
            end else begin
               cnt_d = '0;
            end
         end

         LOAD_A: begin
            if (in_fire_s) begin
               pa_a_d[int'(cnt_q) * W +: W] = in_data;
               if (last_word_s) begin
                  cnt_d = '0;
                  if (key_valid_q) begin
                     state_d = FIRE;
                  end else begin
                     // no key to work with: flag it and drop the operand
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         LOAD_M: begin
            if (in_fire_s) begin
               pa_m_d[int'(cnt_q) * W +: W] = in_data;
               if (last_word_s) begin
                  cnt_d   = '0;
                  state_d = LOAD_MN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         LOAD_MN: begin
            if (in_fire_s) begin
               pa_m_n_d[int'(cnt_q) * W +: W] = in_data;
               if (last_word_s) begin
                  cnt_d   = '0;
                  state_d = LOAD_MP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         LOAD_MP: begin
            // beat 0 carries the two top bits of m_n, beat 1 carries m_prime
            if (in_fire_s) begin
               if (cnt_q == CW'(0)) begin
                  pa_m_n_d[Size+1:Size] = in_data[1:0];
                  cnt_d                 = CW'(1);
               end else begin
                  pa_m_prime_d = in_data[radix+1:0];
                  key_valid_d  = 1'b1;
                  cnt_d        = '0;
                  state_d      = IDLE;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         FIRE: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (pa_done) begin
               result_d = pa_new_a;
               cnt_d    = '0;
               state_d  = UNLOAD;
            end else begin
               state_d = WAIT;
            end
         end

         UNLOAD: begin
            if (out_fire_s) begin
               if (last_word_s) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output register next values, decoded from the next state so outputs are registered.
   always_comb begin
      pa_en_d     = (state_d == FIRE);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == UNLOAD);
      case (state_d)
         IDLE, LOAD_A, LOAD_M, LOAD_MN, LOAD_MP: in_ready_d = 1'b1;
         default:                                in_ready_d = 1'b0;
      endcase
      if (state_d == UNLOAD) begin
         out_data_d = result_d[int'(cnt_d) * W +: W];
         out_last_d = (cnt_d == CW'(NW - 1));
      end else begin
         out_data_d = '0;
         out_last_d = 1'b0;
      end
   end

   // State, counters, operand/result storage and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pa_a_q       <= '0;
         pa_m_q       <= '0;
         pa_m_n_q     <= '0;
         pa_m_prime_q <= '0;
         result_q     <= '0;
         key_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         pa_en_q      <= 1'b0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pa_a_q       <= pa_a_d;
         pa_m_q       <= pa_m_d;
         pa_m_n_q     <= pa_m_n_d;
         pa_m_prime_q <= pa_m_prime_d;
         result_q     <= result_d;
         key_valid_q  <= key_valid_d;
         err_q        <= err_d;
         pa_en_q      <= pa_en_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign pa_a       = pa_a_q;
   assign pa_m       = pa_m_q;
   assign pa_m_n     = pa_m_n_q;
   assign pa_m_prime = pa_m_prime_q;
   assign pa_en      = pa_en_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign key_valid  = key_valid_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_phase_a_loader.sv
// Directed testbench for phase_a_loader: key load, keyless operand, full
// operations with input gaps and output backpressure, and reset in WAIT.
module tb_phase_a_loader;

   localparam int Size  = 3072;
   localparam int RADIX = 54;
   localparam int W     = 64;
   localparam int NW    = Size / W;

   localparam logic [63:0] M_WORD  = 64'h1111_1111_1111_1111;
   localparam logic [63:0] MN_WORD = 64'h2222_2222_2222_2222;
   localparam logic [63:0] MP_WORD = 64'h00AB_CDEF_0123_4567;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic              in_kind;
   logic [Size-1:0]   pa_a;
   logic [Size-1:0]   pa_m;
   logic [Size+1:0]   pa_m_n;
   logic [RADIX+1:0]  pa_m_prime;
   logic              pa_en;
   logic              pa_done;
   logic [Size-1:0]   pa_new_a;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic              out_last;
   logic              key_valid;
   logic              busy;
   logic              err;

   int checks = 0;
   int errors = 0;
   int pa_en_seen = 0;
   int out_valid_seen = 0;

   logic [Size-1:0]   exp_a;
   logic [Size-1:0]   exp_new;
   logic [Size-1:0]   exp_m;
   logic [Size+1:0]   exp_mn;

   phase_a_loader #(.Size(Size), .radix(RADIX), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_kind    (in_kind),
      .pa_a       (pa_a),
      .pa_m       (pa_m),
      .pa_m_n     (pa_m_n),
      .pa_m_prime (pa_m_prime),
      .pa_en      (pa_en),
      .pa_done    (pa_done),
      .pa_new_a   (pa_new_a),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .key_valid  (key_valid),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // count cycles with pa_en / out_valid high (sampled at the edge, before updates)
   always @(posedge clk) begin
      if (pa_en === 1'b1) pa_en_seen <= pa_en_seen + 1;
      if (out_valid === 1'b1) out_valid_seen <= out_valid_seen + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wide(input string tag, input logic [Size+1:0] obs, input logic [Size+1:0] exp);
      logic [Size+63:0] o;
      logic [Size+63:0] e;
      int               first;
      checks++;
      o = {62'd0, obs};
      e = {62'd0, exp};
      first = -1;
      for (int i = NW; i >= 0; i--) begin
         if (o[i*64 +: 64] !== e[i*64 +: 64]) first = i;
      end
      assert (obs === exp) else begin
         errors++;
         if (first < 0) first = 0;
         $error("FAIL %s: word %0d observed 0x%0h expected 0x%0h", tag, first,
                o[first*64 +: 64], e[first*64 +: 64]);
      end
   endtask

   task automatic send(input logic [63:0] d, input logic k);
      in_valid = 1'b1;
      in_data  = d;
      in_kind  = k;
      @(negedge clk);
   endtask

   task automatic send_key();
      for (int k = 0; k < NW; k++) send(M_WORD, 1'b1);
      for (int k = 0; k < NW; k++) send(MN_WORD, 1'b1);
      send(64'h0000_0000_0000_0002, 1'b1);
      chk("key_valid_cleared_before_last", 64'(key_valid), 64'h0);
      send(MP_WORD, 1'b1);
      in_valid = 1'b0;
      chk("key_valid_after_frame", 64'(key_valid), 64'h1);
      chk("m_n_top_bits", 64'(pa_m_n[Size+1:Size]), 64'h2);
      chk("m_prime", 64'(pa_m_prime), MP_WORD);
      chk_wide("pa_m", {2'b00, pa_m}, {2'b00, exp_m});
      chk_wide("pa_m_n", pa_m_n, exp_mn);
      chk("key_busy_after", 64'(busy), 64'h0);
      chk("key_in_ready_after", 64'(in_ready), 64'h1);
   endtask

   task automatic send_operand(input int gap_at);
      for (int k = 0; k < NW; k++) begin
         if (k == gap_at) begin
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk("gap_busy", 64'(busy), 64'h1);
            chk("gap_in_ready", 64'(in_ready), 64'h1);
            chk("gap_partial_word", pa_a[(k-1)*64 +: 64], 64'(k-1));
         end
         send(64'(k), 1'b0);
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input logic bp);
      int got;
      got = 0;
      for (int cyc = 0; cyc < 400 && got < NW; cyc++) begin
         out_ready = bp ? (cyc % 2 == 1) : 1'b1;
         if (out_valid === 1'b1) begin
            chk($sformatf("out_data_%0d", got), out_data, 64'(got + 256));
            chk($sformatf("out_last_%0d", got), 64'(out_last), 64'(got == NW - 1));
            if (out_ready) got++;
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("out_word_count", 64'(got), 64'(NW));
      chk("out_valid_after_unload", 64'(out_valid), 64'h0);
      chk("busy_after_unload", 64'(busy), 64'h0);
      chk("in_ready_after_unload", 64'(in_ready), 64'h1);
   endtask

   task automatic run_op(input int gap_at, input logic bp);
      int base;
      base = pa_en_seen;
      send_operand(gap_at);
      chk("fire_pa_en", 64'(pa_en), 64'h1);
      chk("fire_in_ready", 64'(in_ready), 64'h0);
      chk("fire_busy", 64'(busy), 64'h1);
      chk("fire_err", 64'(err), 64'h0);
      chk_wide("fire_pa_a", {2'b00, pa_a}, {2'b00, exp_a});
      @(negedge clk);
      chk("pa_en_one_cycle", 64'(pa_en), 64'h0);
      repeat (18) @(negedge clk);
      chk_wide("wait_pa_a_held", {2'b00, pa_a}, {2'b00, exp_a});
      chk_wide("wait_pa_m_held", {2'b00, pa_m}, {2'b00, exp_m});
      chk("wait_out_valid", 64'(out_valid), 64'h0);
      chk("wait_busy", 64'(busy), 64'h1);
      pa_done  = 1'b1;
      pa_new_a = exp_new;
      @(negedge clk);
      pa_done  = 1'b0;
      pa_new_a = '0;
      chk("unload_out_valid", 64'(out_valid), 64'h1);
      chk("pa_en_pulse_count", 64'(pa_en_seen - base), 64'h1);
      collect(bp);
   endtask

   initial begin
      int base;
      for (int k = 0; k < NW; k++) begin
         exp_a[k*64 +: 64]   = 64'(k);
         exp_new[k*64 +: 64] = 64'(k + 256);
         exp_m[k*64 +: 64]   = M_WORD;
         exp_mn[k*64 +: 64]  = MN_WORD;
      end
      exp_mn[Size+1:Size] = 2'b10;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_kind   = 1'b0;
      pa_done   = 1'b0;
      pa_new_a  = '0;
      out_ready = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_key_valid", 64'(key_valid), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_pa_en", 64'(pa_en), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_out_data", out_data, 64'h0);
      chk_wide("rst_pa_a", {2'b00, pa_a}, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'h1);

      // operand frame without a key
      base = pa_en_seen;
      send_operand(-1);
      chk("nokey_err_pulse", 64'(err), 64'h1);
      chk("nokey_pa_en", 64'(pa_en), 64'h0);
      @(negedge clk);
      chk("nokey_err_cleared", 64'(err), 64'h0);
      chk("nokey_in_ready", 64'(in_ready), 64'h1);
      chk("nokey_busy", 64'(busy), 64'h0);
      repeat (3) @(negedge clk);
      chk("nokey_pa_en_never", 64'(pa_en_seen - base), 64'h0);

      // key frame
      send_key();

      // pa_done outside WAIT is ignored
      pa_done  = 1'b1;
      pa_new_a = exp_new;
      @(negedge clk);
      pa_done  = 1'b0;
      pa_new_a = '0;
      @(negedge clk);
      chk("idle_pa_done_ignored", 64'(out_valid), 64'h0);
      chk("idle_pa_done_busy", 64'(busy), 64'h0);

      // full operation, gapless input, free-flowing output
      run_op(-1, 1'b0);
      // full operation, input gap mid-frame, alternating output backpressure
      run_op(20, 1'b1);

      // reset while waiting on phase_a
      send_operand(-1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("wrst_in_ready", 64'(in_ready), 64'h0);
      chk("wrst_busy", 64'(busy), 64'h0);
      chk("wrst_key_valid", 64'(key_valid), 64'h0);
      chk("wrst_pa_en", 64'(pa_en), 64'h0);
      chk("wrst_out_valid", 64'(out_valid), 64'h0);
      chk("wrst_out_last", 64'(out_last), 64'h0);
      chk("wrst_err", 64'(err), 64'h0);
      chk("wrst_pa_m_prime", 64'(pa_m_prime), 64'h0);
      chk_wide("wrst_pa_a", {2'b00, pa_a}, '0);
      chk_wide("wrst_pa_m", {2'b00, pa_m}, '0);
      chk_wide("wrst_pa_m_n", pa_m_n, '0);
      base = out_valid_seen;
      pa_done  = 1'b1;
      pa_new_a = exp_new;
      @(negedge clk);
      pa_done  = 1'b0;
      pa_new_a = '0;
      repeat (5) @(negedge clk);
      chk("wrst_late_done_no_output", 64'(out_valid_seen - base), 64'h0);
      chk("wrst_key_still_invalid", 64'(key_valid), 64'h0);
      chk("wrst_in_ready_back", 64'(in_ready), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/phase_a_loader.md
PHASE_A_LOADER -- requirements
Module: phase_a_loader

Interface
REQ-001 SHALL have parameter Size, default 3072: operand/modulus width in bits.
REQ-002 SHALL have parameter radix, default 54: digit width; m_prime width is radix+2.
REQ-003 SHALL have parameter W, default 64: stream word width; Size is a multiple of W, radix+2 <= W; NW = Size/W (48).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, W), in_kind (input, 1): inbound word stream; in_kind is 0 for an operand frame and 1 for a key frame, and is sampled on the first beat only.
REQ-007 SHALL have ports pa_a, pa_m (output, Size), pa_m_n (output, Size+2) and pa_m_prime (output, radix+2): operands driven to the phase_a stage.
REQ-008 SHALL have ports pa_en (output, 1): start pulse to phase_a; pa_done (input, 1): phase_a en_out; pa_new_a (input, Size): phase_a result, valid while pa_done=1.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, W), out_last (output, 1): outbound result stream.
REQ-010 SHALL have ports key_valid (output, 1), busy (output, 1) and err (output, 1).

Function
REQ-011 SHALL implement the states IDLE, LOAD_A, LOAD_M, LOAD_MN, LOAD_MP, FIRE, WAIT and UNLOAD.
REQ-012 SHALL count a beat only when in_valid & in_ready; stalls (in_valid=0) SHALL hold the beat counter and state.
REQ-013 SHALL assert in_ready=1 in IDLE and the LOAD_* states, and 0 in FIRE, WAIT and UNLOAD.
REQ-014 SHALL, from IDLE, treat the first accepted beat as word 0 and go to LOAD_A (in_kind=0) or LOAD_M (in_kind=1).
REQ-015 SHALL, for a key frame, clear key_valid on the first beat.
REQ-016 SHALL order words least-significant first; beat k writes bits [W*k+W-1 : W*k] of the target.
REQ-017 SHALL, for an operand frame, write NW beats into pa_a.
REQ-018 SHALL, for a key frame, write NW beats into pa_m (LOAD_M), then NW beats into pa_m_n[Size-1:0] (LOAD_MN).
REQ-019 SHALL then take one beat supplying pa_m_n[Size+1:Size] = in_data[1:0] and one beat supplying pa_m_prime = in_data[radix+1:0] (LOAD_MP), for 2*NW+2 beats in total.
REQ-020 SHALL, on acceptance of the final key beat, set key_valid=1 on the next cycle and return to IDLE.
REQ-021 SHALL, when the last operand beat is accepted at cycle t with key_valid=1, enter FIRE and drive pa_en=1 in cycle t+1 only, then enter WAIT.
REQ-022 SHALL, when the last operand beat is accepted at cycle t with key_valid=0, pulse err=1 in cycle t+1 only, leave pa_en=0 and return to IDLE.
REQ-023 SHALL keep pa_a, pa_m, pa_m_n and pa_m_prime constant from FIRE until WAIT exits (phase_a resamples a several cycles after the start pulse).
REQ-024 SHALL ignore pa_done outside WAIT.
REQ-025 SHALL, in WAIT, capture pa_new_a on the cycle pa_done=1 and enter UNLOAD on the next cycle.
REQ-026 SHALL, in UNLOAD, drive out_valid=1 and out_data = word j of the captured result, j=0..NW-1, with out_last=1 only for j=NW-1.
REQ-027 SHALL advance j only when out_valid & out_ready, and SHALL hold out_data and out_last stable while stalled.
REQ-028 SHALL go to IDLE after the last beat is accepted; out_valid=0 outside UNLOAD.
REQ-029 SHALL drive busy=1 in every state except IDLE.
REQ-030 SHALL guarantee that pa_en is low for at least one cycle between pulses (phase_a is rising-edge triggered).

Reset
REQ-031 SHALL, while rst=1, force state IDLE, all counters 0, and in_ready, pa_en, out_valid, out_last, key_valid, busy, err = 0.
REQ-032 SHALL, while rst=1, force out_data, pa_a, pa_m, pa_m_n, pa_m_prime and the result register = 0.
REQ-033 SHALL honour reset in any state, including mid-frame, WAIT and UNLOAD; a pa_done arriving after reset SHALL be ignored.

Verification
REQ-034 SHALL cover a key frame: after reset, send 98 beats (m words 0x1111..., m_n words 0x2222..., in_data[1:0]=2'b10, m_prime=0x00AB_CDEF_0123_4567) -> key_valid=1 one cycle after beat 98, pa_m_n[Size+1:Size]=2'b10, and pa_m_prime equals that value.
REQ-035 SHALL cover an operand frame without a key: 48 beats with key_valid=0 -> err high exactly 1 cycle, pa_en never high, in_ready=1 again.
REQ-036 SHALL cover a full operation: after a key frame, send a-word k = k -> pa_en a single pulse one cycle after beat 48, with pa_a word k = k; model pa_done 19 cycles later with new_a word k = k+0x100 -> 48 out beats in order, out_last on beat 47 only.
REQ-037 SHALL cover backpressure: out_ready alternating 1/0 -> each word held until accepted, no word lost or duplicated.
REQ-038 SHALL cover input gaps: in_valid deasserted 3 cycles mid-frame -> the beat count is unchanged and the final pa_a is identical to the gapless case.
REQ-039 SHALL cover reset mid-operation: rst=1 for one cycle in WAIT -> all outputs 0 next cycle, key_valid=0, and a later pa_done produces no out_valid.
